// File: rtl/oam_sprite_ram_pkg.sv
// Shared definitions for the PPU object attribute memory: register offsets,
// memory sizes, evaluator states and the attribute readback mask.
package oam_sprite_ram_pkg;

    localparam logic [2:0] REG_OAMADDR = 3'd3;
    localparam logic [2:0] REG_OAMDATA = 3'd4;

    localparam int unsigned OAM_BYTES     = 256;
    localparam int unsigned SEC_OAM_BYTES = 32;
    localparam logic [3:0]  MAX_SPRITES   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_COPY,
        ST_DONE
    } eval_state_t;

    // Attribute bytes (offset 2 within a sprite) have no storage for bits [4:2].
    function automatic logic [7:0] oam_read_mask(input logic [7:0] addr,
                                                 input logic [7:0] data);
        return (addr[1:0] == 2'd2) ? (data & 8'hE3) : data;
    endfunction

endpackage

// File: rtl/oam_ram.sv
// Primary OAM storage: 256x8, one synchronous write port and two
// combinational read ports (register path and sprite evaluator).
module oam_ram
    import oam_sprite_ram_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr_reg,
    output logic [7:0] rdata_reg,
    input  logic [7:0] raddr_eval,
    output logic [7:0] rdata_eval
);

    logic [7:0] mem [OAM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_reg  = mem[raddr_reg];
    assign rdata_eval = mem[raddr_eval];

endmodule

// File: rtl/oam_sprite_ram.sv
// PPU OAM: $2003/$2004 register interface over primary OAM plus the
// per-scanline sprite evaluator that fills the 32-byte secondary OAM.
module oam_sprite_ram
    import oam_sprite_ram_pkg::*;
#(
    parameter logic [15:0] OAM_BASE = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_data_in,
    input  logic        bus_write_en,
    output logic [7:0]  bus_data_out,
    input  logic        eval_start,
    input  logic [7:0]  eval_scanline,
    input  logic        sprite_size16,
    output logic        eval_busy,
    output logic        eval_done,
    input  logic [4:0]  sec_rd_addr,
    output logic [7:0]  sec_rd_data,
    output logic [3:0]  sprite_count,
    output logic        sprite_overflow,
    output logic        sprite0_hit_cand
);

    logic [7:0]  oam_addr;
    logic        reg_window, sel_addr, sel_data, oam_we;
    logic [7:0]  reg_rd_data, eval_rd_data, eval_rd_addr;
    logic        unused_addr_bits;

    eval_state_t state, state_next;
    logic [7:0]  scanline_q;
    logic        size16_q;
    logic [5:0]  n_idx;
    logic [1:0]  k_idx;
    logic [4:0]  clr_idx;
    logic [8:0]  y_diff;
    logic [7:0]  height;
    logic        in_range, slot_free;
    logic        sec_we;
    logic [4:0]  sec_waddr;
    logic [7:0]  sec_wdata;
    logic [7:0]  sec_oam [SEC_OAM_BYTES];

    // Registers mirror every 8 bytes, so address bits [12:3] are don't-care.
    assign unused_addr_bits = ^bus_addr[12:3];
    assign reg_window = (bus_addr[15:13] == OAM_BASE[15:13]);
    assign sel_addr   = reg_window && (bus_addr[2:0] == REG_OAMADDR);
    assign sel_data   = reg_window && (bus_addr[2:0] == REG_OAMDATA);
    assign oam_we     = bus_write_en && sel_data;

    oam_ram u_oam_ram (
        .clk        (clk),
        .we         (oam_we),
        .waddr      (oam_addr),
        .wdata      (bus_data_in),
        .raddr_reg  (oam_addr),
        .rdata_reg  (reg_rd_data),
        .raddr_eval (eval_rd_addr),
        .rdata_eval (eval_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oam_addr     <= '0;
            bus_data_out <= '0;
        end else begin
            if (bus_write_en && sel_addr) begin
                oam_addr <= bus_data_in;
            end else if (oam_we) begin
                oam_addr <= oam_addr + 8'd1;
            end
            if (sel_addr) begin
                bus_data_out <= oam_addr;
            end else if (sel_data) begin
                bus_data_out <= oam_read_mask(oam_addr, reg_rd_data);
            end else begin
                bus_data_out <= '0;
            end
        end
    end

    assign eval_rd_addr = (state == ST_COPY) ? {n_idx, k_idx} : {n_idx, 2'b00};
    assign y_diff       = {1'b0, scanline_q} - {1'b0, eval_rd_data};
    assign height       = size16_q ? 8'd16 : 8'd8;
    assign in_range     = !y_diff[8] && (y_diff[7:0] < height);
    assign slot_free    = (sprite_count < MAX_SPRITES);
    assign eval_busy    = (state != ST_IDLE);
    assign eval_done    = (state == ST_DONE);

    always_comb begin
        state_next = state;
        sec_we     = 1'b0;
        sec_waddr  = '0;
        sec_wdata  = '0;
        unique case (state)
            ST_IDLE: begin
                if (eval_start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                sec_we    = 1'b1;
                sec_waddr = clr_idx;
                sec_wdata = 8'hFF;
                if (clr_idx == 5'd31) state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (in_range && slot_free) begin
                    sec_we     = 1'b1;
                    sec_waddr  = {sprite_count[2:0], 2'b00};
                    sec_wdata  = eval_rd_data;
                    state_next = ST_COPY;
                end else if (n_idx == 6'd63) begin
                    state_next = ST_DONE;
                end
            end
            ST_COPY: begin
                sec_we    = 1'b1;
                sec_waddr = {sprite_count[2:0], k_idx};
                sec_wdata = eval_rd_data;
                if (k_idx == 2'd3) begin
                    state_next = (n_idx == 6'd63) ? ST_DONE : ST_SCAN;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            scanline_q       <= '0;
            size16_q         <= 1'b0;
            n_idx            <= '0;
            k_idx            <= '0;
            clr_idx          <= '0;
            sprite_count     <= '0;
            sprite_overflow  <= 1'b0;
            sprite0_hit_cand <= 1'b0;
        end else begin
            state <= state_next;
            unique case (state)
                ST_IDLE: begin
                    if (eval_start) begin
                        scanline_q       <= eval_scanline;
                        size16_q         <= sprite_size16;
                        n_idx            <= '0;
                        clr_idx          <= '0;
                        sprite_count     <= '0;
                        sprite_overflow  <= 1'b0;
                        sprite0_hit_cand <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 5'd1;
                end
                ST_SCAN: begin
                    if (in_range && slot_free) begin
                        k_idx <= 2'd1;
                        if (n_idx == 6'd0) sprite0_hit_cand <= 1'b1;
                    end else begin
                        if (in_range) sprite_overflow <= 1'b1;
                        n_idx <= n_idx + 6'd1;
                    end
                end
                ST_COPY: begin
                    k_idx <= k_idx + 2'd1;
                    if (k_idx == 2'd3) begin
                        sprite_count <= sprite_count + 4'd1;
                        n_idx        <= n_idx + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Secondary OAM keeps its contents across reset; CLEAR reinitialises it.
    always_ff @(posedge clk) begin
        if (sec_we) begin
            sec_oam[sec_waddr] <= sec_wdata;
        end
    end

    assign sec_rd_data = sec_oam[sec_rd_addr];

endmodule

// File: tb/tb_oam_sprite_ram.sv
// Directed and randomized bench for oam_sprite_ram, checked against a
// behavioural model of the register file and the sprite evaluation rules.
module tb_oam_sprite_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_in;
    logic        bus_write_en;
    logic [7:0]  bus_data_out;
    logic        eval_start;
    logic [7:0]  eval_scanline;
    logic        sprite_size16;
    logic        eval_busy;
    logic        eval_done;
    logic [4:0]  sec_rd_addr;
    logic [7:0]  sec_rd_data;
    logic [3:0]  sprite_count;
    logic        sprite_overflow;
    logic        sprite0_hit_cand;

    oam_sprite_ram #(.OAM_BASE(16'h2000)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_addr         (bus_addr),
        .bus_data_in      (bus_data_in),
        .bus_write_en     (bus_write_en),
        .bus_data_out     (bus_data_out),
        .eval_start       (eval_start),
        .eval_scanline    (eval_scanline),
        .sprite_size16    (sprite_size16),
        .eval_busy        (eval_busy),
        .eval_done        (eval_done),
        .sec_rd_addr      (sec_rd_addr),
        .sec_rd_data      (sec_rd_data),
        .sprite_count     (sprite_count),
        .sprite_overflow  (sprite_overflow),
        .sprite0_hit_cand (sprite0_hit_cand)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_oam [256];
    logic [7:0] model_addr;
    logic [7:0] img [256];
    int         start_cyc;
    int         exp_cnt;
    logic       exp_ovf;
    logic       exp_hit;
    logic [7:0] exp_sec [32];
    logic [7:0] rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_reg(input logic [15:0] a, input int off);
        return (a[15:13] == 3'b001) && (int'(a[2:0]) == off);
    endfunction

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        logic [7:0] d;
        if (is_reg(a, 3)) return model_addr;
        if (is_reg(a, 4)) begin
            d = model_oam[model_addr];
            if (model_addr % 4 == 2) d = d & 8'hE3;
            return d;
        end
        return 8'h00;
    endfunction

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        bus_addr     = a;
        bus_data_in  = d;
        bus_write_en = 1'b1;
        @(posedge clk); #1;
        bus_write_en = 1'b0;
        if (is_reg(a, 3)) model_addr = d;
        else if (is_reg(a, 4)) begin
            model_oam[model_addr] = d;
            model_addr = model_addr + 8'd1;
        end
    endtask

    task automatic check_rd(input string tag, input logic [15:0] a);
        logic [7:0] e;
        e = exp_read(a);
        bus_addr     = a;
        bus_write_en = 1'b0;
        @(posedge clk); #1;
        check(tag, bus_data_out, e);
    endtask

    task automatic load_img();
        bus_wr(16'h2003, 8'h00);
        for (int i = 0; i < 256; i++) bus_wr((i % 2 == 0) ? 16'h2004 : 16'h3FFC, img[i]);
    endtask

    // Evaluate the sprite rules directly: list every in-range sprite in order.
    task automatic model_eval(input logic [7:0] sl, input logic sz);
        int hits[$];
        int h;
        int y;
        h = sz ? 16 : 8;
        for (int i = 0; i < 64; i++) begin
            y = int'(model_oam[4 * i]);
            if (int'(sl) >= y && int'(sl) - y < h) hits.push_back(i);
        end
        exp_cnt = (hits.size() > 8) ? 8 : hits.size();
        exp_ovf = (hits.size() > 8);
        exp_hit = (hits.size() > 0) && (hits[0] == 0);
        for (int a = 0; a < 32; a++) exp_sec[a] = 8'hFF;
        for (int j = 0; j < exp_cnt; j++)
            for (int b = 0; b < 4; b++) exp_sec[4 * j + b] = model_oam[4 * hits[j] + b];
    endtask

    task automatic start_eval(input logic [7:0] sl, input logic sz);
        eval_scanline = sl;
        sprite_size16 = sz;
        eval_start    = 1'b1;
        start_cyc     = cyc;
        @(posedge clk); #1;
        eval_start = 1'b0;
        check("busy_after_start", eval_busy, 1'b1);
    endtask

    task automatic finish_eval(input logic [7:0] sl, input logic sz);
        int guard;
        int lat;
        guard = 0;
        while (eval_done !== 1'b1 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        lat = cyc - start_cyc;
        model_eval(sl, sz);
        check("eval_done_seen", eval_done, 1'b1);
        check("eval_latency", lat, 97 + 3 * exp_cnt);
        check("sprite_count", sprite_count, exp_cnt);
        check("sprite_overflow", sprite_overflow, exp_ovf);
        check("sprite0_hit_cand", sprite0_hit_cand, exp_hit);
        @(posedge clk); #1;
        check("done_is_pulse", eval_done, 1'b0);
        check("busy_cleared", eval_busy, 1'b0);
        for (int a = 0; a < 32; a++) begin
            sec_rd_addr = 5'(a);
            #1;
            check($sformatf("sec[%0d]", a), sec_rd_data, exp_sec[a]);
        end
    endtask

    task automatic run_eval(input logic [7:0] sl, input logic sz);
        start_eval(sl, sz);
        finish_eval(sl, sz);
    endtask

    initial begin
        rst           = 1'b1;
        bus_addr      = 16'h0000;
        bus_data_in   = 8'h00;
        bus_write_en  = 1'b0;
        eval_start    = 1'b0;
        eval_scanline = 8'h00;
        sprite_size16 = 1'b0;
        sec_rd_addr   = 5'd0;
        model_addr    = 8'h00;
        for (int i = 0; i < 256; i++) model_oam[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_data_out", bus_data_out, 8'h00);
        check("rst_eval_busy", eval_busy, 1'b0);
        check("rst_eval_done", eval_done, 1'b0);
        check("rst_sprite_count", sprite_count, 4'd0);
        check("rst_overflow", sprite_overflow, 1'b0);
        check("rst_hit_cand", sprite0_hit_cand, 1'b0);
        rst = 1'b0;
        check_rd("rst_oamaddr", 16'h2003);

        // Register basics
        bus_wr(16'h2003, 8'h10);
        bus_wr(16'h2004, 8'hAA);
        bus_wr(16'h2004, 8'hBB);
        check_rd("oamaddr_after_incr", 16'h2003);
        bus_wr(16'h2003, 8'h10);
        check_rd("oamdata_read", 16'h2004);
        check_rd("oamdata_read_no_incr", 16'h2004);
        bus_wr(16'h2003, 8'h12);
        bus_wr(16'h2004, 8'hFF);
        bus_wr(16'h2003, 8'h12);
        check_rd("attr_mask", 16'h2004);
        check_rd("mirror_oamaddr", 16'h3FFB);
        check_rd("undecoded_2005", 16'h2005);
        check_rd("undecoded_6004", 16'h6004);

        // DMA-style save / stream / restore
        bus_wr(16'h2003, 8'h05);
        check_rd("dma_save", 16'h2003);
        bus_wr(16'h2003, 8'h00);
        for (int i = 0; i < 256; i++) bus_wr(16'h2004, 8'(i));
        check_rd("dma_addr_wrap", 16'h2003);
        bus_wr(16'h2003, 8'h05);
        check_rd("dma_restore", 16'h2003);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = (i < 4) ? 8'(i) : 8'(8'hFC + 8'(i - 4));
            bus_wr(16'h2003, a);
            check_rd($sformatf("dma_readback_%0h", a), 16'h2004);
        end

        // Sprites 0, 5, 9 at Y=20, scanline 25, 8x8
        for (int i = 0; i < 256; i++) img[i] = (i % 4 == 0) ? 8'hFF : 8'($urandom);
        img[0] = 8'd20; img[20] = 8'd20; img[36] = 8'd20;
        load_img();
        run_eval(8'd25, 1'b0);

        // Ten sprites at Y=100, scanline 110, both sizes
        for (int i = 0; i < 256; i++) img[i] = (i % 4 == 0) ? 8'hFF : 8'($urandom);
        for (int s = 10; s < 20; s++) img[4 * s] = 8'd100;
        load_img();
        run_eval(8'd110, 1'b1);
        run_eval(8'd110, 1'b0);

        // Asynchronous reset in the middle of the first sprite copy
        for (int i = 0; i < 256; i++) img[i] = (i % 4 == 0) ? 8'hFF : 8'($urandom);
        img[0] = 8'd20; img[20] = 8'd20;
        load_img();
        bus_wr(16'h2003, 8'h33);
        start_eval(8'd25, 1'b0);
        repeat (33) @(posedge clk);
        #1;
        check("pre_rst_rd", bus_data_out, 8'h33);
        check("pre_rst_hit", sprite0_hit_cand, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_bus_data_out", bus_data_out, 8'h00);
        check("async_rst_busy", eval_busy, 1'b0);
        check("async_rst_done", eval_done, 1'b0);
        check("async_rst_count", sprite_count, 4'd0);
        check("async_rst_overflow", sprite_overflow, 1'b0);
        check("async_rst_hit", sprite0_hit_cand, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_addr = 8'h00;
        check_rd("post_rst_oamaddr", 16'h2003);
        run_eval(8'd25, 1'b0);

        // Restart ignored while busy; $2004 write during SCAN reaches a later sprite
        for (int i = 0; i < 256; i++) img[i] = (i % 4 == 0) ? 8'hFF : 8'($urandom);
        img[12] = 8'd45; img[68] = 8'd45;
        load_img();
        start_eval(8'd50, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        eval_scanline = 8'd200;
        sprite_size16 = 1'b1;
        eval_start    = 1'b1;
        @(posedge clk); #1;
        eval_start = 1'b0;
        check("restart_busy", eval_busy, 1'b1);
        bus_wr(16'h2003, 8'hF0);
        bus_wr(16'h2004, 8'd47);
        finish_eval(8'd50, 1'b0);

        // Randomized OAM images clustered around the scanline
        for (int t = 0; t < 5; t++) begin
            logic [7:0] sl;
            logic       sz;
            int         base;
            sl   = 8'($urandom_range(0, 239));
            sz   = 1'($urandom_range(0, 1));
            base = (sl >= 32) ? int'(sl) - 32 : 0;
            for (int i = 0; i < 256; i++) begin
                if (i % 4 != 0) img[i] = 8'($urandom);
                else if ($urandom_range(0, 7) == 0) img[i] = 8'hFF;
                else img[i] = 8'(base + $urandom_range(0, 63));
            end
            load_img();
            run_eval(sl, sz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
